// File: rtl/dtw_array_ctrl.sv
// Sequencer for a linear systolic DTW PE chain: query load, reference streaming, drain, min-cost tracking.
// Optional DTW_CTRL_KEEPQ_EN adds start_keepq to reuse an already loaded query.
module dtw_array_ctrl #(
    parameter int WIDTH  = 18,
    parameter int NUM_PE = 8,
    parameter int LEN_W  = 16,
    localparam int IW    = $clog2(NUM_PE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef DTW_CTRL_KEEPQ_EN
    input  logic             start_keepq,
`endif
    input  logic [LEN_W-1:0] cfg_ref_len,
    input  logic [WIDTH-1:0] cfg_thresh,
    output logic             busy,
    input  logic             q_valid,
    output logic             q_ready,
    input  logic [WIDTH-1:0] q_data,
    input  logic             r_valid,
    output logic             r_ready,
    input  logic [WIDTH-1:0] r_data,
    output logic             pe_clr,
    output logic             pe_load,
    output logic [IW-1:0]    pe_load_idx,
    output logic [WIDTH-1:0] pe_load_data,
    output logic             pe_en,
    output logic [WIDTH-1:0] pe_y,
    input  logic [WIDTH-1:0] pe_score,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_score,
    output logic [LEN_W-1:0] res_pos,
    output logic             res_hit
);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] rcnt;
    logic [LEN_W-1:0] col;
    logic [LEN_W-1:0] pos_q;
    logic [WIDTH-1:0] thr_q;
    logic [WIDTH-1:0] min_q;
    logic [IW-1:0]    ldx;
    logic [IW-1:0]    wcnt;
    logic [IW-1:0]    dcnt;
    logic             warm;
    logic             keep;

`ifdef DTW_CTRL_KEEPQ_EN
    logic qfull;
    assign keep = start_keepq && qfull;
`else
    assign keep = 1'b0;
`endif

    assign busy         = (state != IDLE);
    assign pe_clr       = (state == IDLE) && start;
    assign q_ready      = (state == LOAD);
    assign r_ready      = (state == RUN);
    assign pe_load      = q_ready && q_valid;
    assign pe_load_idx  = ldx;
    assign pe_load_data = pe_load ? q_data : '0;
    assign pe_en        = (r_ready && r_valid) || (state == DRAIN);
    assign pe_y         = r_ready ? r_data : '0;
    assign res_valid    = (state == DONE);
    assign res_score    = min_q;
    assign res_pos      = pos_q;
    assign res_hit      = res_valid && (min_q < thr_q);

    // The first NUM_PE-1 enabled steps only fill the chain; no column exits yet.
    assign warm = (wcnt == IW'(NUM_PE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            len_q <= '0;
            rcnt  <= '0;
            col   <= '0;
            pos_q <= '0;
            thr_q <= '0;
            min_q <= '1;
            ldx   <= '0;
            wcnt  <= '0;
            dcnt  <= '0;
`ifdef DTW_CTRL_KEEPQ_EN
            qfull <= 1'b0;
`endif
        end else begin
            if (pe_en) begin
                if (!warm) begin
                    wcnt <= wcnt + 1'b1;
                end else begin
                    if (pe_score < min_q) begin
                        min_q <= pe_score;
                        pos_q <= col;
                    end
                    if (col != '1) col <= col + 1'b1;
                end
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        len_q <= cfg_ref_len;
                        thr_q <= cfg_thresh;
                        min_q <= '1;
                        pos_q <= '0;
                        rcnt  <= '0;
                        col   <= '0;
                        ldx   <= '0;
                        wcnt  <= '0;
                        dcnt  <= '0;
                        if (cfg_ref_len == '0) state <= DONE;
                        else if (keep)         state <= RUN;
                        else                   state <= LOAD;
                    end
                end
                LOAD: begin
                    if (pe_load) begin
                        ldx <= ldx + 1'b1;
                        if (ldx == IW'(NUM_PE - 1)) begin
                            ldx   <= '0;
                            state <= RUN;
`ifdef DTW_CTRL_KEEPQ_EN
                            qfull <= 1'b1;
`endif
                        end
                    end
                end
                RUN: begin
                    if (r_valid) begin
                        rcnt <= rcnt + 1'b1;
                        if (rcnt == len_q - 1'b1) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    dcnt <= dcnt + 1'b1;
                    if (dcnt == IW'(NUM_PE - 2)) state <= DONE;
                end
                DONE: begin
                    if (res_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dtw_array_ctrl.sv
// Self-checking bench for dtw_array_ctrl with NUM_PE=4 and a table-driven PE score stub.
// Table vectors, reset corner cases, and randomized jobs checked against a min/argmin model.
module tb_dtw_array_ctrl;

    localparam int NP = 4;
    localparam int W  = 18;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
`ifdef DTW_CTRL_KEEPQ_EN
    logic          start_keepq;
`endif
    logic [LW-1:0] cfg_ref_len;
    logic [W-1:0]  cfg_thresh;
    logic          busy;
    logic          q_valid, q_ready;
    logic [W-1:0]  q_data;
    logic          r_valid, r_ready;
    logic [W-1:0]  r_data;
    logic          pe_clr, pe_load, pe_en;
    logic [1:0]    pe_load_idx;
    logic [W-1:0]  pe_load_data, pe_y, pe_score;
    logic          res_valid, res_ready, res_hit;
    logic [W-1:0]  res_score;
    logic [LW-1:0] res_pos;

    dtw_array_ctrl #(.WIDTH(W), .NUM_PE(NP), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef DTW_CTRL_KEEPQ_EN
        .start_keepq(start_keepq),
`endif
        .cfg_ref_len(cfg_ref_len), .cfg_thresh(cfg_thresh), .busy(busy),
        .q_valid(q_valid), .q_ready(q_ready), .q_data(q_data),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
        .pe_clr(pe_clr), .pe_load(pe_load), .pe_load_idx(pe_load_idx),
        .pe_load_data(pe_load_data), .pe_en(pe_en), .pe_y(pe_y),
        .pe_score(pe_score), .res_valid(res_valid), .res_ready(res_ready),
        .res_score(res_score), .res_pos(res_pos), .res_hit(res_hit)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit q_loaded = 0;

    // Array stub: column j leaves the last PE on enabled step NP-1+j.
    logic [W-1:0] coltab [0:63];
    int kcnt;

    always @(posedge clk or posedge rst) begin
        if (rst)         kcnt <= 0;
        else if (pe_clr) kcnt <= 0;
        else if (pe_en)  kcnt <= kcnt + 1;
    end

    always_comb begin
        pe_score = '0;
        if (kcnt >= NP - 1 && kcnt - (NP - 1) < 64)
            pe_score = coltab[kcnt-(NP-1)];
    end

    typedef struct packed {
        logic [7:0]      len;
        logic [W-1:0]    thr;
        logic [1:0]      qgap;
        logic [1:0]      rmode;
        logic [3:0]      hold;
        logic [63:0]     cols;
        logic [W-1:0]    es;
        logic [7:0]      ep;
        logic            eh;
    } vec_t;

    vec_t tab [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_q_ready"}, q_ready, 0);
        chk({tag, "_r_ready"}, r_ready, 0);
        chk({tag, "_pe_load"}, pe_load, 0);
        chk({tag, "_pe_load_idx"}, pe_load_idx, 0);
        chk({tag, "_pe_load_data"}, pe_load_data, 0);
        chk({tag, "_pe_en"}, pe_en, 0);
        chk({tag, "_pe_y"}, pe_y, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_score"}, res_score, 32'h3FFFF);
        chk({tag, "_res_pos"}, res_pos, 0);
        chk({tag, "_res_hit"}, res_hit, 0);
    endtask

    task automatic run_job(input int len, input int thr, input int qgap,
                           input int rmode, input bit keepq, input int hold,
                           input bit chk_lat, input logic [W-1:0] es,
                           input int ep, input bit eh);
        int ld, rh, en, qg, lat, first_r, exp_ld;
        bit seen, skip;
        skip = keepq && q_loaded && len != 0;
        @(negedge clk);
        cfg_ref_len = LW'(len);
        cfg_thresh = W'(thr);
        start = 1;
`ifdef DTW_CTRL_KEEPQ_EN
        start_keepq = keepq;
`endif
        #1;
        chk("idle_busy", busy, 0);
        chk("pe_clr", pe_clr, 1);
        @(posedge clk);
        #1;
        start = 0;
        cfg_ref_len = LW'($urandom);
        cfg_thresh = W'($urandom);
`ifdef DTW_CTRL_KEEPQ_EN
        start_keepq = 0;
`endif
        ld = 0; rh = 0; en = 0; qg = 0; lat = 0; first_r = 0; seen = 0;
        for (int cyc = 1; cyc <= 400 && !seen; cyc++) begin
            @(negedge clk);
            q_valid = (qg == 0);
            if (qg > 0) qg--;
            q_data = W'($urandom);
            case (rmode)
                0:       r_valid = 1;
                1:       r_valid = (cyc % 2) == 1;
                default: r_valid = ($urandom_range(0, 1) == 1);
            endcase
            r_data = W'($urandom);
            #1;
            if (res_valid) begin
                seen = 1;
                lat = cyc;
            end else begin
                if (pe_load) begin
                    chk("load_idx", pe_load_idx, ld);
                    chk("load_data", pe_load_data, q_data);
                    ld++;
                    qg = qgap;
                end
                if (r_ready) begin
                    if (first_r == 0) first_r = cyc;
                    chk("en_mirror", pe_en, r_valid);
                    if (r_valid) begin
                        chk("pe_y", pe_y, r_data);
                        rh++;
                    end
                end else if (pe_en) begin
                    chk("drain_y", pe_y, 0);
                end
                if (pe_en) en++;
            end
        end
        q_valid = 0;
        r_valid = 0;
        chk("done_seen", seen, 1);
        exp_ld = (len == 0 || skip) ? 0 : NP;
        chk("loads", ld, exp_ld);
        chk("ref_hs", rh, len);
        chk("en_cycles", en, len == 0 ? 0 : len + NP - 1);
        if (chk_lat) begin
            chk("latency", lat, len == 0 ? 1 : (skip ? len + NP : 2 * NP + len));
            if (len != 0) chk("first_r", first_r, skip ? 1 : NP + 1);
        end
        chk("res_score", res_score, es);
        chk("res_pos", res_pos, ep);
        chk("res_hit", res_hit, eh);
        if (exp_ld == NP) q_loaded = 1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            start = 1;
            #1;
            chk("hold_valid", res_valid, 1);
            chk("hold_busy", busy, 1);
            chk("hold_score", res_score, es);
            chk("hold_pos", res_pos, ep);
            chk("hold_hit", res_hit, eh);
        end
        @(negedge clk);
        start = 0;
        res_ready = 1;
        @(posedge clk);
        #1;
        res_ready = 0;
        chk("idle_after", busy, 0);
        chk("valid_after", res_valid, 0);
    endtask

    initial begin
        int len, thr, p, rh;
        logic [W-1:0] m;
        logic [63:0] cv;
        bit kq;

        rst = 1; start = 0; cfg_ref_len = '0; cfg_thresh = '0;
        q_valid = 0; q_data = '0; r_valid = 0; r_data = '0; res_ready = 0;
`ifdef DTW_CTRL_KEEPQ_EN
        start_keepq = 0;
`endif
        for (int i = 0; i < 64; i++) coltab[i] = '0;
        #1;
        chk_rst("reset");
        chk("reset_pe_clr", pe_clr, 0);
        @(negedge clk);
        rst = 0;

        tab[0] = '{8'd4, 18'd5,   2'd0, 2'd0, 4'd1, 64'h00000000_05030709, 18'd3, 8'd2, 1'b1};
        tab[1] = '{8'd4, 18'd5,   2'd2, 2'd0, 4'd1, 64'h00000000_05030709, 18'd3, 8'd2, 1'b1};
        tab[2] = '{8'd4, 18'd100, 2'd0, 2'd1, 4'd1, 64'h00000000_04040404, 18'd4, 8'd0, 1'b1};
        tab[3] = '{8'd0, 18'd5,   2'd0, 2'd0, 4'd5, 64'h0, 18'h3FFFF, 8'd0, 1'b0};
        tab[4] = '{8'd5, 18'd3,   2'd0, 2'd0, 4'd1, 64'h00000002_02060608, 18'd2, 8'd3, 1'b1};
        tab[5] = '{8'd3, 18'd2,   2'd1, 2'd2, 4'd1, 64'h00000000_00090902, 18'd2, 8'd0, 1'b0};
        tab[6] = '{8'd1, 18'd1,   2'd0, 2'd0, 4'd1, 64'h0, 18'd0, 8'd0, 1'b1};
        tab[7] = '{8'd8, 18'h3FFFF, 2'd0, 2'd0, 4'd1, 64'h0D0E0F10_11121314, 18'd13, 8'd7, 1'b1};

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 64; j++) coltab[j] = '0;
            cv = tab[i].cols;
            for (int j = 0; j < 8; j++) coltab[j] = W'(cv[j*8 +: 8]);
            run_job(int'(tab[i].len), int'(tab[i].thr), int'(tab[i].qgap),
                    int'(tab[i].rmode), 0, int'(tab[i].hold),
                    tab[i].qgap == 0 && tab[i].rmode == 0,
                    tab[i].es, int'(tab[i].ep), tab[i].eh);
        end

        @(negedge clk);
        cfg_ref_len = 16'd6;
        cfg_thresh = 18'd5;
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        rh = 0;
        for (int c = 0; c < 40 && rh < 2; c++) begin
            @(negedge clk);
            q_valid = 1;
            r_valid = 1;
            #1;
            if (r_ready) rh++;
        end
        chk("rst_reached_run", rh, 2);
        @(posedge clk);
        #2;
        rst = 1;
        #1;
        chk_rst("midrun_rst");
        q_valid = 0;
        r_valid = 0;
        q_loaded = 0;
        @(negedge clk);
        rst = 0;

        for (int j = 0; j < 64; j++) coltab[j] = '0;
        coltab[0] = 18'd6; coltab[1] = 18'd1; coltab[2] = 18'd8;
`ifdef DTW_CTRL_KEEPQ_EN
        kq = 1;
`else
        kq = 0;
`endif
        run_job(3, 2, 0, 0, kq, 1, 1, 18'd1, 1, 1'b1);
`ifdef DTW_CTRL_KEEPQ_EN
        coltab[0] = 18'd3; coltab[1] = 18'd9; coltab[2] = 18'd2;
        run_job(3, 2, 0, 0, 1, 1, 1, 18'd2, 2, 1'b0);
`endif

        for (int t = 0; t < 20; t++) begin
            len = $urandom_range(1, 10);
            thr = $urandom_range(0, 16);
            for (int j = 0; j < 64; j++) coltab[j] = '0;
            for (int j = 0; j < len; j++) coltab[j] = W'($urandom_range(0, 15));
            m = '1;
            p = 0;
            for (int j = 0; j < len; j++) begin
                if (coltab[j] < m) begin
                    m = coltab[j];
                    p = j;
                end
            end
`ifdef DTW_CTRL_KEEPQ_EN
            kq = ($urandom_range(0, 1) == 1);
`else
            kq = 0;
`endif
            begin
                int qg, rm;
                qg = $urandom_range(0, 2);
                rm = $urandom_range(0, 2);
                run_job(len, thr, qg, rm, kq, 1, qg == 0 && rm == 0,
                        m, p, m < W'(thr));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
